// File: rtl/sparc_muldiv_iter.sv
// Iterative SPARCv8 multiply/divide: radix-2 shift-add multiplier and restoring divider.
// Define MULDIV_DIV_EN to build the divider; without it divide ops finish at once with illegal_op.
module sparc_muldiv_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [WIDTH-1:0] y_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rd,
   output logic [WIDTH-1:0] y_out,
   output logic [3:0]       icc_out,
   output logic             icc_we,
   output logic             division_by_zero,
   output logic             illegal_op
);
   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH - 1){1'b0}}};
   localparam logic [WIDTH-1:0] MaxPos  = ~MinNeg;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

   state_e             r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc, w_acc_next, w_acc_init, w_prod;
   logic [WIDTH-1:0]   r_opnd, w_opnd_init, r_rd, r_y_out, w_res_rd, w_res_y, w_mag1, w_mag2;
   logic [WIDTH:0]     w_mul_sum;
   logic [3:0]         r_icc;
   logic               r_sign, r_set_icc, r_skip, r_dbz, r_ill;
   logic               w_accept, w_neg1, w_neg2, w_sign, w_skip_req, w_dbz_req, w_ill_req;
   logic               w_res_ovf;
`ifdef MULDIV_DIV_EN
   logic               r_div, r_signed, r_pre_ovf;
   logic [WIDTH-1:0]   r_y, w_q;
   logic               w_negy;
   logic [2*WIDTH-1:0] w_dvd, w_mag_dvd, w_div_next;
   logic [WIDTH:0]     w_rem, w_diff;
`else
   logic               w_unused_y;
`endif

   assign busy             = (r_state == StRun) || (r_state == StFix);
   assign done             = (r_state == StDone);
   assign rd               = r_rd;
   assign y_out            = r_y_out;
   assign icc_out          = r_icc;
   assign division_by_zero = r_dbz;
   assign illegal_op       = r_ill;
   assign icc_we           = done && r_set_icc && !r_dbz && !r_ill;

   assign w_accept   = start && !busy;
   assign w_neg1     = op[0] && rs1[WIDTH-1];
   assign w_neg2     = op[0] && rs2[WIDTH-1];
   assign w_mag1     = w_neg1 ? -rs1 : rs1;
   assign w_mag2     = w_neg2 ? -rs2 : rs2;
   assign w_skip_req = w_dbz_req || w_ill_req;

   // Multiply step: add multiplicand into the high half when the multiplier LSB is set.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_prod    = r_sign ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
   assign w_negy      = op[0] && y_in[WIDTH-1];
   assign w_dvd       = {y_in, rs1};
   assign w_mag_dvd   = w_negy ? -w_dvd : w_dvd;
   assign w_dbz_req   = op[1] && (rs2 == '0);
   assign w_ill_req   = 1'b0;
   assign w_sign      = op[1] ? (w_negy ^ w_neg2) : (w_neg1 ^ w_neg2);
   assign w_acc_init  = op[1] ? w_mag_dvd : {{WIDTH{1'b0}}, w_mag2};
   assign w_opnd_init = op[1] ? w_mag2 : w_mag1;
   // Restoring step: high half is the partial remainder, quotient bits shift in at the bottom.
   assign w_rem       = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff      = w_rem - {1'b0, r_opnd};
   assign w_div_next  = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
   assign w_acc_next  = r_div ? w_div_next : {w_mul_sum, r_acc[WIDTH-1:1]};
   assign w_q         = r_acc[WIDTH-1:0];
`else
   assign w_dbz_req   = 1'b0;
   assign w_ill_req   = op[1];
   assign w_sign      = w_neg1 ^ w_neg2;
   assign w_acc_init  = {{WIDTH{1'b0}}, w_mag2};
   assign w_opnd_init = w_mag1;
   assign w_acc_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
   assign w_unused_y  = ^y_in;
`endif

   always_comb begin
      w_res_rd  = w_prod[WIDTH-1:0];
      w_res_y   = w_prod[2*WIDTH-1:WIDTH];
      w_res_ovf = 1'b0;
`ifdef MULDIV_DIV_EN
      if (r_div) begin
         w_res_y = r_y;
         if (!r_signed) begin
            w_res_ovf = r_pre_ovf;
            w_res_rd  = r_pre_ovf ? '1 : w_q;
         end else if (!r_sign) begin
            w_res_ovf = r_pre_ovf || w_q[WIDTH-1];
            w_res_rd  = w_res_ovf ? MaxPos : w_q;
         end else begin
            w_res_ovf = r_pre_ovf || (w_q > MinNeg);
            w_res_rd  = w_res_ovf ? MinNeg : -w_q;
         end
      end
`endif
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle, StDone: begin
            if (start) w_state_d = w_skip_req ? StFix : StRun;
            else       w_state_d = StIdle;
         end
         // One extra RUN cycle after the last iteration keeps latency at WIDTH+2.
         StRun:   if (r_cnt == LastCnt) w_state_d = StFix;
         StFix:   w_state_d = StDone;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_sign    <= 1'b0;
         r_set_icc <= 1'b0;
         r_skip    <= 1'b0;
         r_dbz     <= 1'b0;
         r_ill     <= 1'b0;
         r_rd      <= '0;
         r_y_out   <= '0;
         r_icc     <= '0;
`ifdef MULDIV_DIV_EN
         r_div     <= 1'b0;
         r_signed  <= 1'b0;
         r_pre_ovf <= 1'b0;
         r_y       <= '0;
`endif
      end else if (w_accept) begin
         r_cnt     <= '0;
         r_acc     <= w_acc_init;
         r_opnd    <= w_opnd_init;
         r_sign    <= w_sign;
         r_set_icc <= op[2];
         r_skip    <= w_skip_req;
         r_dbz     <= w_dbz_req;
         r_ill     <= w_ill_req;
`ifdef MULDIV_DIV_EN
         r_div     <= op[1];
         r_signed  <= op[0];
         r_pre_ovf <= op[1] && (w_mag_dvd[2*WIDTH-1:WIDTH] >= w_mag2);
         r_y       <= y_in;
`endif
      end else if (r_state == StRun && r_cnt != LastCnt) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == StFix && !r_skip) begin
         r_rd    <= w_res_rd;
         r_y_out <= w_res_y;
         r_icc   <= {w_res_rd[WIDTH-1], (w_res_rd == '0), w_res_ovf, 1'b0};
      end
   end
endmodule
